// File: rtl/cnt_ctrl_pkg.sv
// cnt_ctrl_pkg: shared definitions for the counter sequencing controller.
//   - cnt_state_t : controller state encoding (IDLE/RUN/PAUSE/DONE)
//   - CNT_WIDTH   : default counter width
//   - CNT_REP_W   : default period-count width
package cnt_ctrl_pkg;

  localparam int unsigned CNT_WIDTH = 4;
  localparam int unsigned CNT_REP_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } cnt_state_t;

endpackage

// File: rtl/cnt_core.sv
// cnt_core: WIDTH-bit synchronous up counter.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (count -> 0)
//   clr   : synchronous clear (count -> 0), dominates en
//   en    : advance count by one; when low the count holds
//   count : current count value
module cnt_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: sequencing controller for the up counter. Starts,
// pauses, aborts and terminates a counting run against a latched terminal
// value and a latched number of periods.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   start     : run request pulse, accepted in IDLE or DONE
//   pause     : level, holds the count while high in RUN/PAUSE
//   abort     : pulse, forces IDLE from any state
//   cfg_limit : terminal value (count runs 0..cfg_limit), latched on start
//   cfg_reps  : periods per run (0 = free-run), latched on start
//   count     : current count value
//   tc        : one-cycle pulse per completed period
//   busy      : high in RUN or PAUSE
//   done      : high in DONE
//   rep_cnt   : completed periods in the current run
module counter_seq_ctrl
  import cnt_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH,
  parameter int unsigned REP_W = CNT_REP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic [REP_W-1:0] cfg_reps,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] rep_cnt
);

  cnt_state_t       state_q, state_d;
  logic [WIDTH-1:0] lim_q;
  logic [REP_W-1:0] reps_q;
  logic [REP_W-1:0] rep_q, rep_d, rep_inc;
  logic             tc_q, tc_d;
  logic             busy_q, done_q;
  logic             latch_cfg;
  logic             cnt_en, cnt_clr;

  cnt_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (count)
  );

  assign rep_inc = rep_q + 1'b1;

  // A PAUSE cycle with pause released is itself an advancing cycle, so a
  // pause held for P cycles lengthens the period by exactly P cycles.
  always_comb begin
    state_d   = state_q;
    rep_d     = rep_q;
    tc_d      = 1'b0;
    latch_cfg = 1'b0;
    cnt_en    = 1'b0;
    cnt_clr   = 1'b0;
    if (abort) begin
      state_d = IDLE;
      rep_d   = '0;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d   = RUN;
            rep_d     = '0;
            cnt_clr   = 1'b1;
            latch_cfg = 1'b1;
          end
        end
        RUN, PAUSE: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (count != lim_q) begin
            state_d = RUN;
            cnt_en  = 1'b1;
          end else begin
            rep_d = rep_inc;
            tc_d  = 1'b1;
            if ((reps_q != '0) && (rep_inc == reps_q)) begin
              state_d = DONE;
            end else begin
              state_d = RUN;
              cnt_clr = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lim_q   <= '0;
      reps_q  <= '0;
      rep_q   <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
      tc_q    <= tc_d;
      busy_q  <= (state_d == RUN) || (state_d == PAUSE);
      done_q  <= (state_d == DONE);
      if (latch_cfg) begin
        lim_q  <= cfg_limit;
        reps_q <= cfg_reps;
      end
    end
  end

  assign tc      = tc_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rep_cnt = rep_q;

endmodule
